aes_192_ctr_ctrl: RTL and testbench
===================================

# aes_192_ctr_ctrl

Sequencer for the aes_192 core in CTR mode. It accepts a stream of 128-bit plain/cipher blocks over a valid/ready handshake and owns the 128-bit counter block. For each block it drives the core through one start/complete cycle, XORs the returned keystream with the data, and presents the result on a valid/ready output. It sits between the system data path and a single aes_192 instance and replaces the free-running start/hold discipline with a managed one.

## Interface
- CTR_W, 32: width of the incrementing low field of the counter block (1..128).
- TIMEOUT, 64: core completion watchdog limit in cycles (only with the watchdog compiled in).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  one-cycle pulse that latches cfg_key and cfg_iv. Accepted only in IDLE; ignored otherwise.
- cfg_key  in  192  AES-192 key.
- cfg_iv  in  128  initial counter block.
- in_valid / in_ready  in / out  1 / 1  input handshake.
- in_data  in  128  plain or cipher text block.
- in_last  in  1  marks the last block of a message.
- out_valid / out_ready  out / in  1 / 1  output handshake.
- out_data  out  128  in_data XOR keystream.
- out_last  out  1  in_last of the same block.
- core_start  out  1  to core start.
- core_state  out  128  to core state; equals the counter register.
- core_key  out  192  to core key; equals the key register.
- core_out  in  128  keystream from the core.
- core_out_valid  in  1  core completion flag.
- busy  out  1  high in any state other than IDLE.
- blk_cnt  out  32  blocks delivered in the current message.
- err  out  1  sticky watchdog error.

## Operation
- Registers: key_reg, ctr_reg, key_ok, data_reg, last_reg.
- Counter arithmetic: ctr_reg[CTR_W-1:0] increments modulo 2^CTR_W. Upper bits never change.
- State machine:
  - IDLE: in_ready = key_ok. cfg_load sets key_reg, ctr_reg and key_ok, and clears err and blk_cnt. in_valid&&in_ready latches data_reg and last_reg, then goes to RUN. If cfg_load and in_valid occur in the same cycle, cfg_load wins, in_ready is forced 0 and the block is not taken.
  - RUN: core_start = 1 and core_state/core_key are held stable. When core_out_valid = 1: out_data <= data_reg ^ core_out, out_last <= last_reg, ctr_reg increments, go to HOLD.
  - HOLD: out_valid = 1 with outputs stable. On out_ready: blk_cnt increments, or clears to 0 if out_last; go to GAP.
  - GAP: core_start = 0. Stay until core_out_valid = 0, with a minimum of 1 cycle, then go to IDLE. This guarantees a clean 0->1 start edge for the next block.
- core_start is 0 in every state except RUN.
- blk_cnt wraps modulo 2^32.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, core_start 0, core_state 0, core_key 0, busy 0, blk_cnt 0, err 0. State is IDLE and key_ok is 0.
- Input accepted at edge 0. core_start is high from cycle 1.
- Core asserts completion at cycle N. out_valid is high from cycle N+1.
- Minimum spacing between accepted blocks is core latency + 3 cycles (RUN entry, HOLD, GAP).
- out_ready may be held low indefinitely. The core is idle meanwhile and the counter has already advanced.
- rst mid-operation: the block in flight is lost, key_ok is cleared, and cfg_load is required again.

## Configuration
- AES_CTR_WATCHDOG_EN defined:
  - A cycle counter runs in RUN.
  - If TIMEOUT cycles elapse without core_out_valid, err is set, the block is discarded (no output, counter not incremented), and the state goes to GAP.
  - err clears only on cfg_load or rst.
- AES_CTR_WATCHDOG_EN undefined: RUN waits indefinitely and err is tied to 0.

## Test plan
Bench core model: core_out = core_state ^ core_key[127:0], with core_out_valid asserted 12 cycles after the core_start rising edge. The model holds core_out_valid until start falls.

- cfg_load with iv = 0x…0000_0005, then one block in_data = 0 -> out_data = (iv ^ key[127:0]); core_state for the next block is 0x…0006; out_valid first seen 13 cycles after acceptance.
- iv low 32 bits = 0xFFFFFFFF, upper bits = 0xA5…: two blocks -> second core_state low bits = 0x00000000, upper bits unchanged.
- out_ready held low 20 cycles on block 1 with in_valid high -> in_ready stays 0, out_data stable, no second core_start edge; releasing out_ready accepts block 2 after GAP.
- Message of 3 blocks, in_last on the third -> out_last only on the third; blk_cnt reads 1, 2, then 0 after the last handshake.
- in_valid with no cfg_load since reset -> in_ready stays 0. cfg_load and in_valid in the same cycle -> key loaded, block not taken until the next cycle.
- AES_CTR_WATCHDOG_EN, TIMEOUT = 16, core model never completes -> err = 1 at RUN cycle 16, no out_valid, counter unchanged; next cfg_load clears err.

Source files
------------

// File: rtl/aes_192_ctr_if.sv
// aes_192_ctr_if: block stream in/out handshakes between system data path and the CTR sequencer.
interface aes_192_ctr_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_192_ctr_ctrl.sv
// aes_192_ctr_ctrl: CTR-mode sequencer driving one aes_192 core per block.
// Optional RUN watchdog enabled by defining AES_CTR_WATCHDOG_EN.
module aes_192_ctr_ctrl #(
    parameter int CTR_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic [191:0] cfg_key,
    input  logic [127:0] cfg_iv,
    aes_192_ctr_if.slave s,
    output logic         core_start,
    output logic [127:0] core_state,
    output logic [191:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_out_valid,
    output logic         busy,
    output logic [31:0]  blk_cnt,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, GAP} state_t;
    localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? '1 : ((128'd1 << CTR_W) - 128'd1);
`ifdef AES_CTR_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif
    state_t       state_q, state_d;
    logic [191:0] key_q, key_d;
    logic [127:0] ctr_q, ctr_d, data_q, data_d, out_data_q, out_data_d;
    logic         key_ok_q, key_ok_d, last_q, last_d, out_last_q, out_last_d;
    logic         err_q, err_d;
    logic [31:0]  blk_cnt_q, blk_cnt_d, wd_q, wd_d;
    logic [127:0] ctr_inc;
    logic         take;
    // Only the low CTR_W bits roll; the upper nonce bits are preserved.
    assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    assign take    = (state_q == IDLE) && key_ok_q && !cfg_load && s.in_valid;
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        key_ok_d   = key_ok_q;
        data_d     = data_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        err_d      = err_q;
        blk_cnt_d  = blk_cnt_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    key_d     = cfg_key;
                    ctr_d     = cfg_iv;
                    key_ok_d  = 1'b1;
                    err_d     = 1'b0;
                    blk_cnt_d = '0;
                end else if (take) begin
                    data_d  = s.in_data;
                    last_d  = s.in_last;
                    wd_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (core_out_valid) begin
                    out_data_d = data_q ^ core_out;
                    out_last_d = last_q;
                    ctr_d      = ctr_inc;
                    state_d    = HOLD;
                end else if (WD_EN && wd_q == 32'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            HOLD: begin
                if (s.out_ready) begin
                    blk_cnt_d = out_last_q ? '0 : blk_cnt_q + 32'd1;
                    state_d   = GAP;
                end
            end
            default: state_d = core_out_valid ? GAP : IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            ctr_q      <= '0;
            key_ok_q   <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
            blk_cnt_q  <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ctr_q      <= ctr_d;
            key_ok_q   <= key_ok_d;
            data_q     <= data_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
            blk_cnt_q  <= blk_cnt_d;
            wd_q       <= wd_d;
        end
    end
    assign s.in_ready  = (state_q == IDLE) && key_ok_q && !cfg_load;
    assign s.out_valid = (state_q == HOLD);
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign core_start  = (state_q == RUN);
    assign core_state  = ctr_q;
    assign core_key    = key_q;
    assign busy        = (state_q != IDLE);
    assign blk_cnt     = blk_cnt_q;
    assign err         = WD_EN & err_q;
endmodule

// File: tb/tb_aes_192_ctr_ctrl.sv
// tb_aes_192_ctr_ctrl: directed vector bench with a 12-cycle behavioural core model.
module tb_aes_192_ctr_ctrl;
    localparam logic [191:0] KEY = 192'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_0112233445566778;
    localparam logic [127:0] IV0 = 128'h0000_0000_0000_0000_0000_0000_0000_0005;
    localparam logic [127:0] IV1 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF;
    logic         clk, rst, cfg_load, core_start, core_out_valid, busy, err, core_dead;
    logic [191:0] cfg_key, core_key;
    logic [127:0] cfg_iv, core_state, core_out;
    logic [31:0]  blk_cnt;
    logic [3:0]   ccnt;
    int           checks, errors;
    aes_192_ctr_if sif();
    aes_192_ctr_ctrl #(.CTR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .s(sif), .core_start(core_start), .core_state(core_state), .core_key(core_key),
        .core_out(core_out), .core_out_valid(core_out_valid), .busy(busy),
        .blk_cnt(blk_cnt), .err(err)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    // Core model: completes 12 cycles after start rises, holds completion until start falls.
    always @(posedge clk)
        if (rst || !core_start) ccnt <= 0;
        else if (ccnt != 4'd12) ccnt <= ccnt + 4'd1;
    assign core_out_valid = !core_dead && ccnt == 4'd12;
    assign core_out       = core_state ^ core_key[127:0];
    typedef struct {
        logic         cfg;
        logic [127:0] iv;
        logic [127:0] data;
        logic         last;
        logic [127:0] ctr;
        logic [31:0]  blk;
        int           delay;
    } vec_t;
    vec_t vt[5];
    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("idle_wait", busy, 0);
    endtask
    task automatic run_vec(input vec_t v);
        logic [127:0] exp;
        int n, lat;
        exp = v.data ^ v.ctr ^ KEY[127:0];
        @(negedge clk);
        if (v.cfg) begin
            cfg_iv = v.iv; cfg_load = 1;
            @(negedge clk); cfg_load = 0;
        end
        n = 0;
        while (!sif.in_ready && n < 40) begin @(negedge clk); n++; end
        chk("in_ready_wait", sif.in_ready, 1);
        sif.in_data = v.data; sif.in_last = v.last; sif.in_valid = 1;
        @(posedge clk); #1; sif.in_valid = 0;
        chk("core_start", core_start, 1);
        chk("core_state", core_state, v.ctr);
        chk("core_key", core_key, KEY);
        lat = 0;
        while (!sif.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, 13);
        if (v.delay > 0) begin
            sif.in_valid = 1;
            for (int i = 0; i < v.delay; i++) begin
                @(posedge clk); #1;
                chk("stall_in_ready", sif.in_ready, 0);
                chk("stall_out_data", sif.out_data, exp);
                chk("stall_start", core_start, 0);
            end
            sif.in_valid = 0;
        end
        chk("out_valid", sif.out_valid, 1);
        chk("out_data", sif.out_data, exp);
        chk("out_last", sif.out_last, v.last);
        sif.out_ready = 1;
        @(posedge clk); #1; sif.out_ready = 0;
        chk("blk_cnt", blk_cnt, v.blk);
        chk("out_valid_drop", sif.out_valid, 0);
        wait_idle();
    endtask
    initial begin
        checks = 0; errors = 0;
        rst = 1; cfg_load = 0; cfg_key = KEY; cfg_iv = '0; core_dead = 0;
        sif.in_valid = 0; sif.in_data = '0; sif.in_last = 0; sif.out_ready = 0;
        vt[0] = '{1'b1, IV0, 128'h0, 1'b0, IV0, 32'd1, 0};
        vt[1] = '{1'b0, '0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0,
                  128'h6, 32'd2, 20};
        vt[2] = '{1'b0, '0, 128'h11112222_33334444_55556666_77778888, 1'b1,
                  128'h7, 32'd0, 0};
        vt[3] = '{1'b1, IV1, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 1'b0,
                  IV1, 32'd1, 0};
        vt[4] = '{1'b0, '0, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 1'b1,
                  128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000, 32'd0, 3};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_out_data", sif.out_data, 0);
        chk("rst_out_last", sif.out_last, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_state", core_state, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst = 0;
        sif.in_valid = 1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("nokey_in_ready", sif.in_ready, 0);
            chk("nokey_busy", busy, 0);
        end
        @(negedge clk); cfg_iv = IV0; cfg_load = 1;
        #1 chk("cfg_race_in_ready", sif.in_ready, 0);
        @(posedge clk); #1;
        chk("cfg_race_busy", busy, 0);
        chk("cfg_race_key", core_key, KEY);
        chk("cfg_race_ctr", core_state, IV0);
        cfg_load = 0;
        #1 chk("cfg_race_ready_next", sif.in_ready, 1);
        sif.in_valid = 0;
        for (int i = 0; i < 5; i++) run_vec(vt[i]);
        chk("ctr_after_wrap", core_state, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000001);
        core_dead = 1;
        @(negedge clk); cfg_iv = IV0; cfg_load = 1;
        @(negedge clk); cfg_load = 0;
        sif.in_data = 128'h55; sif.in_last = 0; sif.in_valid = 1;
        @(posedge clk); #1; sif.in_valid = 0;
`ifdef AES_CTR_WATCHDOG_EN
        repeat (15) @(posedge clk);
        #1;
        chk("wd_err_early", err, 0);
        chk("wd_start_early", core_start, 1);
        @(posedge clk); #1;
        chk("wd_err_set", err, 1);
        chk("wd_no_out", sif.out_valid, 0);
        chk("wd_start_off", core_start, 0);
        wait_idle();
        chk("wd_ctr_kept", core_state, IV0);
        chk("wd_err_sticky", err, 1);
        core_dead = 0;
        @(negedge clk); cfg_load = 1;
        @(negedge clk); cfg_load = 0;
        #1 chk("wd_err_clear", err, 0);
`else
        repeat (30) @(posedge clk);
        #1;
        chk("nowd_err", err, 0);
        chk("nowd_start", core_start, 1);
        chk("nowd_no_out", sif.out_valid, 0);
        core_dead = 0;
        begin
            int n = 0;
            while (!sif.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        end
        chk("nowd_out_valid", sif.out_valid, 1);
        chk("nowd_out_data", sif.out_data, 128'h55 ^ IV0 ^ KEY[127:0]);
        sif.out_ready = 1;
        @(posedge clk); #1; sif.out_ready = 0;
        wait_idle();
        chk("nowd_ctr", core_state, 128'h6);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
